// File: rtl/demux18_deser.sv
// Serial-to-parallel receiver for the 8:1 mux path: per-lane demux plus
// in-order sweep reassembly into words delivered over valid/ready.
module demux18_deser #(
  parameter int LANES = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
  input  logic [SEL_W-1:0] s,
  input  logic             in_valid,
  output logic [LANES-1:0] lanes,
  output logic [LANES-1:0] word,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             seq_err,
  output logic             overrun
);

  typedef enum logic {HUNT, COLLECT} state_t;

  localparam logic [SEL_W-1:0] IDX_ONE  = SEL_W'(1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(LANES - 1);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   exp_q, exp_d;
  logic [LANES-2:0]   asm_q, asm_d;
  logic [LANES-1:0]   lanes_q, lanes_d;
  logic [LANES-1:0]   word_q, word_d;
  logic               word_valid_q, word_valid_d;
  logic               seq_err_q, seq_err_d;
  logic               overrun_q, overrun_d;
  logic               frame_done;
  logic               xfer;

  // Demux path runs on every beat regardless of framing state.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lanes_d[gi] = (in_valid && (s == SEL_W'(gi))) ? in : lanes_q[gi];
  end

  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    asm_d      = asm_q;
    seq_err_d  = 1'b0;
    frame_done = 1'b0;
    if (in_valid) begin
      case (state_q)
        HUNT: begin
          if (s == '0) begin
            asm_d[0] = in;
            exp_d    = IDX_ONE;
            state_d  = COLLECT;
          end
        end
        COLLECT: begin
          if (s == exp_q) begin
            if (s == IDX_LAST) begin
              frame_done = 1'b1;
              state_d    = HUNT;
              exp_d      = '0;
            end else begin
              asm_d[s] = in;
              exp_d    = exp_q + IDX_ONE;
            end
          end else begin
            seq_err_d = 1'b1;
            // A stray s==0 is treated as the start of a fresh sweep.
            if (s == '0) begin
              asm_d[0] = in;
              exp_d    = IDX_ONE;
            end else begin
              state_d = HUNT;
              exp_d   = '0;
            end
          end
        end
        default: begin
          state_d = HUNT;
          exp_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    xfer         = word_valid_q && word_ready;
    word_d       = word_q;
    word_valid_d = word_valid_q && !xfer;
    overrun_d    = overrun_q;
    if (frame_done) begin
      // The slot is free if empty or being drained on this very edge.
      if (!word_valid_q || xfer) begin
        word_d       = {in, asm_q};
        word_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      exp_q        <= '0;
      asm_q        <= '0;
      lanes_q      <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      seq_err_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      exp_q        <= exp_d;
      asm_q        <= asm_d;
      lanes_q      <= lanes_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      seq_err_q    <= seq_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign lanes      = lanes_q;
  assign word       = word_q;
  assign word_valid = word_valid_q;
  assign seq_err    = seq_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_demux18_deser.sv
// Scoreboard bench for demux18_deser: directed sweeps plus randomized beats
// checked against a frame-level reference model.
module tb_demux18_deser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_bit = 1'b0;
  logic [2:0] s = '0;
  logic       in_valid = 1'b0;
  logic [7:0] lanes;
  logic [7:0] word;
  logic       word_valid;
  logic       word_ready = 1'b0;
  logic       seq_err;
  logic       overrun;

  demux18_deser #(.LANES(8), .SEL_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in         (in_bit),
    .s          (s),
    .in_valid   (in_valid),
    .lanes      (lanes),
    .word       (word),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .seq_err    (seq_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         tag;
    logic [7:0] lanes;
    logic [7:0] word;
    logic       wv;
    logic       se;
    logic       ov;
  } st_t;

  st_t        sq[$];
  logic [7:0] wq[$];

  // Reference model: frame progress is "how many in-order bits have arrived".
  logic [7:0] m_lanes, m_word, fbits;
  logic       m_wv, m_se, m_ov;
  int         have;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_lanes = '0; m_word = '0; fbits = '0;
    m_wv = 1'b0; m_se = 1'b0; m_ov = 1'b0;
    have = -1;
  endtask

  task automatic m_beat(input logic v, input logic [2:0] ss, input logic b, input logic rdy);
    logic xfer, done;
    int k;
    k = int'(ss);
    xfer = m_wv && rdy;
    done = 1'b0;
    m_se = 1'b0;
    if (v) begin
      m_lanes[k] = b;
      if (have < 0) begin
        if (k == 0) begin fbits[0] = b; have = 1; end
      end else if (k == have) begin
        fbits[k] = b;
        have++;
        if (have == 8) begin done = 1'b1; have = -1; end
      end else begin
        m_se = 1'b1;
        if (k == 0) begin fbits[0] = b; have = 1; end
        else have = -1;
      end
    end
    if (done && m_wv && !xfer) begin
      m_ov = 1'b1;
    end else begin
      if (xfer) m_wv = 1'b0;
      if (done) begin
        m_word = fbits;
        m_wv   = 1'b1;
        wq.push_back(fbits);
      end
    end
  endtask

  // One clock of stimulus; the expected post-edge state is queued for the monitor.
  task automatic step(input logic v, input logic [2:0] ss, input logic b, input logic rdy);
    st_t e;
    @(posedge clk);
    #1;
    in_valid   = v;
    s          = ss;
    in_bit     = b;
    word_ready = rdy;
    m_beat(v, ss, b, rdy);
    e.tag = cyc + 1; e.lanes = m_lanes; e.word = m_word;
    e.wv = m_wv; e.se = m_se; e.ov = m_ov;
    sq.push_back(e);
  endtask

  task automatic sweep(input logic [7:0] w, input logic rdy);
    for (int k = 0; k < 8; k++) step(1'b1, 3'(k), w[k], rdy);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int k = 0; k < n; k++) step(1'b0, 3'd0, 1'b0, rdy);
  endtask

  task automatic beats(input logic [7:0] w, input int lo, input int hi, input logic rdy);
    for (int k = lo; k <= hi; k++) step(1'b1, 3'(k), w[k], rdy);
  endtask

  // Drop rst_n between edges and confirm outputs clear without a clock.
  task automatic do_reset();
    @(posedge clk);
    #4;
    rst_n = 1'b0;
    #1;
    check("async_lanes", lanes, 8'h00);
    check("async_word", word, 8'h00);
    check("async_word_valid", {7'd0, word_valid}, 8'h00);
    check("async_seq_err", {7'd0, seq_err}, 8'h00);
    check("async_overrun", {7'd0, overrun}, 8'h00);
    m_reset();
    wq.delete();
    sq.delete();
    in_valid   = 1'b0;
    word_ready = 1'b0;
    @(posedge clk);
    #5;
    rst_n = 1'b1;
  endtask

  // Monitor: compares queued expectations and scores words on each handshake.
  initial begin
    st_t e;
    forever begin
      @(posedge clk);
      #3;
      while (sq.size() > 0 && sq[0].tag <= cyc) begin
        e = sq.pop_front();
        check("lanes", lanes, e.lanes);
        check("word", word, e.word);
        check("word_valid", {7'd0, word_valid}, {7'd0, e.wv});
        check("seq_err", {7'd0, seq_err}, {7'd0, e.se});
        check("overrun", {7'd0, overrun}, {7'd0, e.ov});
      end
      if (word_valid === 1'b1) begin
        checks++;
        if (wq.size() == 0) begin
          failures++;
          $display("FAIL word_unexpected actual=%h required=none t=%0t", word, $time);
        end else begin
          if (word !== wq[0]) begin
            failures++;
            $display("FAIL word_sb actual=%h required=%h t=%0t", word, wq[0], $time);
          end
          if (word_ready) void'(wq.pop_front());
        end
      end
    end
  end

  initial begin
    logic [2:0] gen;
    logic [2:0] rs;
    logic       rv;
    m_reset();
    #1 rst_n = 1'b0;
    #1;
    check("reset_lanes", lanes, 8'h00);
    check("reset_word", word, 8'h00);
    check("reset_word_valid", {7'd0, word_valid}, 8'h00);
    check("reset_overrun", {7'd0, overrun}, 8'h00);
    #12 rst_n = 1'b1;

    sweep(8'hD5, 1'b1);
    idle(2, 1'b1);
    // Back-to-back sweeps with ready high: no loss.
    sweep(8'hA7, 1'b1);
    sweep(8'h4E, 1'b1);
    idle(2, 1'b1);
    // Backpressure: second frame dropped, overrun set.
    sweep(8'hD5, 1'b0);
    sweep(8'h3C, 1'b0);
    idle(3, 1'b0);
    idle(3, 1'b1);
    // Sequence error then clean sweep.
    step(1'b1, 3'd0, 1'b1, 1'b1);
    step(1'b1, 3'd1, 1'b0, 1'b1);
    step(1'b1, 3'd2, 1'b1, 1'b1);
    step(1'b1, 3'd5, 1'b0, 1'b1);
    sweep(8'h5A, 1'b1);
    idle(2, 1'b1);
    // Restart on s==0.
    step(1'b1, 3'd0, 1'b0, 1'b1);
    step(1'b1, 3'd1, 1'b1, 1'b1);
    sweep(8'hC3, 1'b1);
    idle(2, 1'b1);
    // Simultaneous completion and transfer.
    sweep(8'h11, 1'b0);
    beats(8'h99, 0, 6, 1'b0);
    step(1'b1, 3'd7, 1'b1, 1'b1);
    idle(2, 1'b1);
    // Hunt discard after reset.
    do_reset();
    beats(8'hF8, 3, 7, 1'b1);
    idle(2, 1'b1);
    // Async reset mid-frame.
    beats(8'h6B, 0, 4, 1'b1);
    do_reset();
    sweep(8'h96, 1'b1);
    idle(2, 1'b1);

    // Randomized beats: mostly in-order with occasional jumps and gaps.
    for (int blk = 0; blk < 2; blk++) begin
      gen = 3'd0;
      for (int n = 0; n < 300; n++) begin
        rv = ($urandom_range(0, 4) != 0);
        rs = ($urandom_range(0, 11) == 0) ? 3'($urandom_range(0, 7)) : gen;
        if (rv) gen = rs + 3'd1;
        step(rv, rs, 1'($urandom_range(0, 1)),
             (blk == 0) ? 1'b1 : 1'($urandom_range(0, 2) != 0));
      end
      idle(3, 1'b1);
      if (blk == 0) do_reset();
    end

    idle(3, 1'b1);
    @(posedge clk);
    #5;
    check("words_drained", 8'(wq.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux18_deser.md
# demux18_deser

Serial-to-parallel receiver for the 8:1 mux path: it takes the single-bit output of an 8:1 mux, whose select sweeps 0→7, and demultiplexes each bit back to lane `s`. It also reassembles complete in-order sweeps into 8-bit words and delivers them over a valid/ready handshake. It sits at the far end of the mux datapath and rebuilds the original parallel `in` vector.

## Interface
- `LANES`, 8: number of lanes / word width; fixed at 8 for this block.
- `SEL_W`, 3: select width, log2(LANES).

- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in`  in  1  serial data bit (mux `out`).
- `s`  in  3  lane index of the current bit (mux select).
- `in_valid`  in  1  qualifies `in`/`s` this cycle (beat).
- `lanes`  out  8  registered demux outputs.
- `word`  out  8  last completed frame.
- `word_valid`  out  1  `word` holds an unconsumed frame.
- `word_ready`  in  1  consumer accepts `word`.
- `seq_err`  out  1  one-cycle pulse on an out-of-order select.
- `overrun`  out  1  sticky; a completed frame was dropped.

## Operation
- Reset values: `lanes`=0, `word`=0, `word_valid`=0, `seq_err`=0, `overrun`=0, assembly register=0, state=HUNT, expected index=0.
- Demux path: on every beat, `lanes[s] <= in`; other lanes hold. This is independent of frame state and errors.
- Frame FSM has two states:
  - HUNT: waits for a beat with `s==0`. That beat stores `asm[0]`, sets expected=1 and moves to COLLECT. Beats with `s!=0` are discarded with no `seq_err`.
  - COLLECT, beat with `s==expected`: store `asm[s]` and increment expected.
  - COLLECT, `s==7` match: frame completes; go to HUNT with expected=0.
  - COLLECT, mismatch: pulse `seq_err`. If `s==0`, restart the frame with this bit (expected=1, stay in COLLECT); otherwise go to HUNT.
  - No beat: hold.
- Bit order: the bit carried with `s=k` becomes `word[k]`. The completed word is {`in`, `asm[6:0]`}.
- Output slot, on frame completion:
  - If `word_valid`=0, or `word_valid && word_ready` in the same cycle: load `word` and set `word_valid`=1.
  - Otherwise: drop the new frame, keep `word` unchanged, set `overrun`=1.
- Handshake: a transfer occurs when `word_valid && word_ready` at a clock edge. `word_valid` then clears unless a new frame loads in that same edge. `word` and `word_valid` are stable while waiting for `word_ready`.
- `overrun` clears only on reset.

## Timing
- `lanes` latency: one cycle; visible after the edge that samples the beat.
- Word latency: `word_valid` rises the cycle after the edge that samples the `s=7` beat.
- Minimum frame: 8 consecutive beats. With back-to-back frames and `word_ready` tied high, one word is delivered every 8 cycles with no loss.
- `seq_err` is high for exactly one cycle, following the offending beat's edge.
- `rst_n` low at any time, including mid-frame or with `word_valid` set, clears all state immediately, without waiting for `clk`. The partial frame is lost. The first edge after deassertion behaves as if in HUNT.
- Simultaneous completion and transfer on the same edge: the old word transfers and the new word loads; `word_valid` stays 1 and `overrun` is not set.

## Test plan
- Reset then sweep: beats s=0..7 carrying bits of 8'b1101_0101 (bit s at step s), with `word_ready`=1. Required: `word`=8'hD5 with a one-cycle `word_valid` after the s=7 beat, `lanes`=8'hD5, `seq_err`=0.
- Backpressure: two back-to-back sweeps (0xD5 then 0x3C) with `word_ready`=0. Required: `word` stays 0xD5 and `word_valid` stays 1; `overrun` rises after the second sweep. Raising `word_ready` clears `word_valid`.
- Sequence error: beats s=0,1,2,5. Required: `seq_err` pulses once after the s=5 beat, FSM goes to HUNT, and `lanes[5]` still updates. A following clean 0..7 sweep yields the correct word.
- Restart on 0: beats s=0,1,0..7. Required: one `seq_err` pulse, and the final word is built from the second sweep only.
- Hunt discard: beats s=3..7 after reset. Required: no `word_valid`, no `seq_err`, and `lanes[7:3]` updated.
- Async reset mid-frame: drop `rst_n` between clock edges after s=4. Required: all outputs read 0 before the next edge; a new 0..7 sweep completes normally.
